// File: rtl/spi_ram_master_if.sv
// Host-side request/response bundle for spi_ram_master.
// The "master" modport is the host issuing requests; the "slave" modport
// is the SPI RAM master block that accepts and completes them.
interface spi_ram_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master that turns one host RAM request into an address frame followed
// by a data frame for the SPI slave/RAM wrapper. Every frame is one START
// cycle, 11 MSB-first bits {rw, cmd[1:0], payload}, and a SS_n-high gap.
// Read-data frames keep SS_n low for a turnaround wait and 8 MISO captures.
// Separate write/read address caches let a repeated address skip its
// address frame. SS_n, MOSI and all host outputs come straight from flops.
module spi_ram_master #(
    parameter int GAP_CYCLES = 2,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_CACHE = 1
) (
    input  logic              clk,
    input  logic              rst,
    spi_ram_master_if.slave   host,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    // One counter serves SHIFT, WAIT, CAPTURE and GAP, so size it for the longest
    localparam int MAX_PARAM = (GAP_CYCLES > RD_LATENCY) ? GAP_CYCLES : RD_LATENCY;
    localparam int CNT_MAX   = (MAX_PARAM > 11) ? MAX_PARAM : 11;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(10);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT,
        CAPTURE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_phase_q, data_phase_d;
    logic             write_q, write_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       wr_cache_addr_q, wr_cache_addr_d;
    logic             wr_cache_valid_q, wr_cache_valid_d;
    logic [7:0]       rd_cache_addr_q, rd_cache_addr_d;
    logic             rd_cache_valid_q, rd_cache_valid_d;
    logic [7:0]       rx_q, rx_d;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             cache_hit;
    logic [10:0]      frame_d;

    // The 11-bit word for a frame: command bits select kind and phase, reads send a zero payload
    function automatic logic [10:0] build_frame(input logic is_write, input logic is_data,
                                                input logic [7:0] addr, input logic [7:0] wdata);
        logic [10:0] word;
        case ({is_write, is_data})
            2'b10:   word = {3'b000, addr};
            2'b11:   word = {3'b001, wdata};
            2'b00:   word = {3'b110, addr};
            default: word = {3'b111, 8'h00};
        endcase
        return word;
    endfunction

    assign host.req_ready = ready_q;
    assign host.busy      = busy_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rdata_q;
    assign SS_n           = ss_n_q;
    assign MOSI           = mosi_q;

    // Sequencer: next state, counters, caches and the next value of every registered output
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        data_phase_d     = data_phase_q;
        write_d          = write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wr_cache_addr_d  = wr_cache_addr_q;
        wr_cache_valid_d = wr_cache_valid_q;
        rd_cache_addr_d  = rd_cache_addr_q;
        rd_cache_valid_d = rd_cache_valid_q;
        rx_d             = rx_q;
        rsp_valid_d      = 1'b0;
        rdata_d          = rdata_q;
        cache_hit        = 1'b0;
        frame_d          = '0;
        mosi_d           = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.req_valid && ready_q) begin
                    write_d = host.req_write;
                    addr_d  = host.req_addr;
                    wdata_d = host.req_wdata;
                    if (ADDR_CACHE != 0) begin
                        if (host.req_write) begin
                            cache_hit = wr_cache_valid_q && (wr_cache_addr_q == host.req_addr);
                        end else begin
                            cache_hit = rd_cache_valid_q && (rd_cache_addr_q == host.req_addr);
                        end
                    end
                    data_phase_d = cache_hit;
                    state_d      = START;
                    cnt_d        = '0;
                end
            end
            START: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d = '0;
                    if (data_phase_q && !write_q) begin
                        state_d = (RD_LATENCY == 0) ? CAPTURE : WAIT;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAPTURE: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == CAP_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (!data_phase_q) begin
                        data_phase_d = 1'b1;
                        state_d      = START;
                        if (write_q) begin
                            wr_cache_addr_d  = addr_q;
                            wr_cache_valid_d = 1'b1;
                        end else begin
                            rd_cache_addr_d  = addr_q;
                            rd_cache_valid_d = 1'b1;
                        end
                    end else begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        if (!write_q) begin
                            rdata_d = rx_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ss_n_d  = (state_d == IDLE) || (state_d == GAP);
        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;
        if (state_d == SHIFT) begin
            frame_d = build_frame(write_d, data_phase_d, addr_d, wdata_d);
            mosi_d  = frame_d[4'd10 - cnt_d[3:0]];
        end
    end

    // State and output registers; reset abandons any frame and drops both caches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            data_phase_q     <= 1'b0;
            write_q          <= 1'b0;
            addr_q           <= 8'h00;
            wdata_q          <= 8'h00;
            wr_cache_addr_q  <= 8'h00;
            wr_cache_valid_q <= 1'b0;
            rd_cache_addr_q  <= 8'h00;
            rd_cache_valid_q <= 1'b0;
            rx_q             <= 8'h00;
            ss_n_q           <= 1'b1;
            mosi_q           <= 1'b0;
            ready_q          <= 1'b1;
            busy_q           <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rdata_q          <= 8'h00;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            data_phase_q     <= data_phase_d;
            write_q          <= write_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            wr_cache_addr_q  <= wr_cache_addr_d;
            wr_cache_valid_q <= wr_cache_valid_d;
            rd_cache_addr_q  <= rd_cache_addr_d;
            rd_cache_valid_q <= rd_cache_valid_d;
            rx_q             <= rx_d;
            ss_n_q           <= ss_n_d;
            mosi_q           <= mosi_d;
            ready_q          <= ready_d;
            busy_q           <= busy_d;
            rsp_valid_q      <= rsp_valid_d;
            rdata_q          <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Scoreboard bench for spi_ram_master. Stimulus pushes the expected SPI frames
// and responses; a slave/RAM model decodes frames off SS_n/MOSI and answers on
// MISO, and a response monitor checks latency and read data on rsp_valid.
module tb_spi_ram_master;

    localparam int GAP    = 2;
    localparam int RD_LAT = 1;
    localparam int LEN_NORM = 12;
    localparam int LEN_RD   = 12 + RD_LAT + 8;

    typedef struct {
        logic [10:0] bits;
        int          len;
    } frame_t;

    typedef struct {
        bit          is_read;
        logic [7:0]  rdata;
        int          lat;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SS_n;
    logic MOSI;
    logic MISO = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    frame_t     exp_frames[$];
    rsp_t       exp_rsp[$];
    int         accept_q[$];
    logic [7:0] mem [256];

    spi_ram_master_if bus ();

    spi_ram_master #(
        .GAP_CYCLES (GAP),
        .RD_LATENCY (RD_LAT),
        .ADDR_CACHE (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    // Free-running cycle number, read at negedges to time accepts and responses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [10:0] wa(input logic [7:0] a); return {3'b000, a}; endfunction
    function automatic logic [10:0] wd(input logic [7:0] d); return {3'b001, d}; endfunction
    function automatic logic [10:0] ra(input logic [7:0] a); return {3'b110, a}; endfunction
    function automatic logic [10:0] rd();                    return {3'b111, 8'h00}; endfunction

    task automatic push_frame(input logic [10:0] bits, input int len);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        exp_frames.push_back(f);
    endtask

    task automatic push_rsp(input bit is_read, input logic [7:0] rdata, input int lat);
        rsp_t r;
        r.is_read = is_read;
        r.rdata   = rdata;
        r.lat     = lat;
        exp_rsp.push_back(r);
    endtask

    // Present one request and hold it until the handshake completes
    task automatic apply_stimulus(input logic write, input logic [7:0] addr, input logic [7:0] wdata);
        int n = 0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = write;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 100);
        check_output("req_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_rsp.size() > 0 || exp_frames.size() > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_rsp", 32'(exp_rsp.size()), 32'd0);
        check_output("drain_frames", 32'(exp_frames.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Slave/RAM model: decode each frame, check it against the expectation, answer reads on MISO
    initial begin
        int         low_cnt;
        int         exp_len;
        bit         frame_done;
        bit         rd_frame;
        logic [10:0] shift_in;
        logic [7:0] s_waddr;
        logic [7:0] s_raddr;
        logic [7:0] s_rdata;
        frame_t     f;
        low_cnt = 0;
        exp_len = 0;
        frame_done = 1'b0;
        rd_frame = 1'b0;
        shift_in = '0;
        s_waddr = 8'h00;
        s_raddr = 8'h00;
        s_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt = 0;
                frame_done = 1'b0;
                rd_frame = 1'b0;
                MISO = 1'b1;
            end else if (!SS_n) begin
                low_cnt++;
                if (low_cnt == 1) begin
                    check_output("start_mosi", 32'(MOSI), 32'd0);
                end else if (low_cnt <= 12) begin
                    shift_in = {shift_in[9:0], MOSI};
                end
                if (low_cnt == 12) begin
                    frame_done = 1'b1;
                    if (exp_frames.size() == 0) begin
                        check_output("frame_unexpected", 32'(exp_frames.size()), 32'd1);
                        exp_len = 0;
                    end else begin
                        f = exp_frames.pop_front();
                        check_output("frame_bits", 32'(shift_in), 32'(f.bits));
                        exp_len = f.len;
                    end
                    case (shift_in[10:8])
                        3'b000: s_waddr = shift_in[7:0];
                        3'b001: mem[s_waddr] = shift_in[7:0];
                        3'b110: s_raddr = shift_in[7:0];
                        3'b111: begin
                            s_rdata = mem[s_raddr];
                            rd_frame = 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (rd_frame && low_cnt >= 13 + RD_LAT && low_cnt <= 20 + RD_LAT) begin
                    MISO = s_rdata[7 - (low_cnt - 13 - RD_LAT)];
                end else begin
                    MISO = 1'b1;
                end
            end else begin
                if (frame_done) check_output("frame_len", 32'(low_cnt), 32'(exp_len));
                low_cnt = 0;
                frame_done = 1'b0;
                rd_frame = 1'b0;
                MISO = 1'b1;
            end
        end
    end

    // Response monitor: log accepts, then match every rsp_valid against the scoreboard
    initial begin
        rsp_t r;
        int   a;
        forever begin
            @(negedge clk);
            if (!rst && bus.req_valid && bus.req_ready) accept_q.push_back(cyc);
            if (!rst && bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check_output("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
                end else begin
                    r = exp_rsp.pop_front();
                    a = (accept_q.size() > 0) ? accept_q.pop_front() : -1000;
                    check_output("rsp_latency", 32'(cyc - a), 32'(r.lat));
                    if (r.is_read) check_output("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
                end
            end
        end
    end

    // Directed sequence
    initial begin
        int n;
        int acc1;
        int acc2;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_ss_n", 32'(SS_n), 32'd1);
        check_output("reset_mosi", 32'(MOSI), 32'd0);
        check_output("reset_ready", 32'(bus.req_ready), 32'd1);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset_rdata", 32'(bus.rsp_rdata), 32'd0);

        $display("[TB] full write 0xD7 <= 0xD3");
        push_frame(wa(8'hD7), LEN_NORM); push_frame(wd(8'hD3), LEN_NORM); push_rsp(0, 8'h00, 29);
        apply_stimulus(1'b1, 8'hD7, 8'hD3);
        wait_done();

        $display("[TB] full read 0xD7");
        push_frame(ra(8'hD7), LEN_NORM); push_frame(rd(), LEN_RD); push_rsp(1, 8'hD3, 38);
        apply_stimulus(1'b0, 8'hD7, 8'h00);
        wait_done();

        $display("[TB] cached read 0xD7, then read 0x10");
        push_frame(rd(), LEN_RD); push_rsp(1, 8'hD3, 24);
        apply_stimulus(1'b0, 8'hD7, 8'h00);
        wait_done();
        push_frame(ra(8'h10), LEN_NORM); push_frame(rd(), LEN_RD); push_rsp(1, 8'h4A, 38);
        apply_stimulus(1'b0, 8'h10, 8'h00);
        wait_done();

        $display("[TB] independent caches on 0x22");
        push_frame(ra(8'h22), LEN_NORM); push_frame(rd(), LEN_RD); push_rsp(1, 8'h78, 38);
        apply_stimulus(1'b0, 8'h22, 8'h00);
        wait_done();
        push_frame(wa(8'h22), LEN_NORM); push_frame(wd(8'h99), LEN_NORM); push_rsp(0, 8'h00, 29);
        apply_stimulus(1'b1, 8'h22, 8'h99);
        wait_done();
        push_frame(wd(8'h3C), LEN_NORM); push_rsp(0, 8'h00, 15);
        apply_stimulus(1'b1, 8'h22, 8'h3C);
        wait_done();
        push_frame(rd(), LEN_RD); push_rsp(1, 8'h3C, 24);
        apply_stimulus(1'b0, 8'h22, 8'h00);
        wait_done();

        $display("[TB] reset during data-frame shift");
        apply_stimulus(1'b1, 8'h22, 8'h55);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("pre_reset_ss_n", 32'(SS_n), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        accept_q.delete();
        @(negedge clk);
        check_output("abort_ss_n", 32'(SS_n), 32'd1);
        check_output("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("abort_ready", 32'(bus.req_ready), 32'd1);
        repeat (30) @(negedge clk);
        push_frame(wa(8'h22), LEN_NORM); push_frame(wd(8'h66), LEN_NORM); push_rsp(0, 8'h00, 29);
        apply_stimulus(1'b1, 8'h22, 8'h66);
        wait_done();
        push_frame(ra(8'h22), LEN_NORM); push_frame(rd(), LEN_RD); push_rsp(1, 8'h66, 38);
        apply_stimulus(1'b0, 8'h22, 8'h00);
        wait_done();

        $display("[TB] back-to-back writes with req_valid held");
        push_frame(wa(8'h40), LEN_NORM); push_frame(wd(8'h11), LEN_NORM); push_rsp(0, 8'h00, 29);
        push_frame(wd(8'h12), LEN_NORM); push_rsp(0, 8'h00, 15);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h40;
        bus.req_wdata = 8'h11;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 100);
        acc1 = cyc;
        @(posedge clk);
        #1;
        bus.req_wdata = 8'h12;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 100);
        acc2 = cyc;
        check_output("b2b_accept_gap", 32'(acc2 - acc1), 32'd29);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_done();

        $display("[TB] read back 0x40, then check rdata holds across a write");
        push_frame(ra(8'h40), LEN_NORM); push_frame(rd(), LEN_RD); push_rsp(1, 8'h12, 38);
        apply_stimulus(1'b0, 8'h40, 8'h00);
        wait_done();
        push_frame(wd(8'h13), LEN_NORM); push_rsp(0, 8'h00, 15);
        apply_stimulus(1'b1, 8'h40, 8'h13);
        wait_done();
        check_output("rdata_hold", 32'(bus.rsp_rdata), 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
